// File: rtl/id_ex_buf_if.sv
// Handshake bundle between the IF/ID side, the decode buffer and the execute stage.
// Upstream carries raw pc/instr; downstream carries the decoded head packet and occupancy.
interface id_ex_buf_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) ();
   localparam int CW = $clog2(DEPTH + 1);

   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_pc;
   logic [31:0]     in_instr;
   logic            flush;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [6:0]      opcode;
   logic [4:0]      rd;
   logic [2:0]      funct3;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm;
   logic            alu_src1;
   logic            alu_src2;
   logic [1:0]      alu_op;
   logic            mem_read;
   logic            mem_write;
   logic            mem_to_reg;
   logic            reg_write;
   logic            is_branch;
   logic            is_jump;
   logic            illegal;
   logic [CW-1:0]   count;

   modport master (
      output in_valid, in_pc, in_instr, flush, out_ready,
      input  in_ready, out_valid, out_pc, opcode, rd, funct3, rs1, rs2, funct7, imm,
             alu_src1, alu_src2, alu_op, mem_read, mem_write, mem_to_reg, reg_write,
             is_branch, is_jump, illegal, count
   );

   modport slave (
      input  in_valid, in_pc, in_instr, flush, out_ready,
      output in_ready, out_valid, out_pc, opcode, rd, funct3, rs1, rs2, funct7, imm,
             alu_src1, alu_src2, alu_op, mem_read, mem_write, mem_to_reg, reg_write,
             is_branch, is_jump, illegal, count
   );
endinterface

// File: rtl/id_ex_buf.sv
// RV32I/RV64I decoder feeding a DEPTH-entry elastic buffer; one cycle from accept to head.
// in_ready depends only on occupancy; flush clears everything on the next edge.
module id_ex_buf #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input logic          clk_i,
   input logic          rstn_i,
   id_ex_buf_if.slave   bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [6:0]      opcode;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [6:0]      funct7;
      logic [XLEN-1:0] imm;
      logic            alu_src1;
      logic            alu_src2;
      logic [1:0]      alu_op;
      logic            mem_read;
      logic            mem_write;
      logic            mem_to_reg;
      logic            reg_write;
      logic            is_branch;
      logic            is_jump;
      logic            illegal;
   } pkt_t;

   pkt_t        dec;
   pkt_t        head;
   logic [31:0] ins;
   logic [31:0] imm32;
   logic        wr;

   always_comb begin
      ins        = bus.in_instr;
      imm32      = '0;
      wr         = 1'b0;
      dec        = '0;
      dec.pc     = bus.in_pc;
      dec.opcode = ins[6:0];
      dec.rd     = ins[11:7];
      dec.funct3 = ins[14:12];
      dec.rs1    = ins[19:15];
      dec.rs2    = ins[24:20];
      dec.funct7 = ins[31:25];
      case (ins[6:0])
         OP_LUI: begin
            dec.rs1      = '0;
            imm32        = {ins[31:12], 12'b0};
            dec.alu_src2 = 1'b1;
            wr           = 1'b1;
         end
         OP_AUIPC: begin
            imm32        = {ins[31:12], 12'b0};
            dec.alu_src1 = 1'b1;
            dec.alu_src2 = 1'b1;
            wr           = 1'b1;
         end
         OP_JAL: begin
            imm32        = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            dec.alu_src1 = 1'b1;
            dec.is_jump  = 1'b1;
            wr           = 1'b1;
         end
         OP_JALR: begin
            imm32        = {{20{ins[31]}}, ins[31:20]};
            dec.alu_src1 = 1'b1;
            dec.alu_src2 = 1'b1;
            dec.is_jump  = 1'b1;
            wr           = 1'b1;
         end
         OP_BRANCH: begin
            imm32         = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            dec.alu_op    = 2'b01;
            dec.is_branch = 1'b1;
         end
         OP_LOAD: begin
            imm32          = {{20{ins[31]}}, ins[31:20]};
            dec.alu_src2   = 1'b1;
            dec.mem_read   = 1'b1;
            dec.mem_to_reg = 1'b1;
            wr             = 1'b1;
         end
         OP_STORE: begin
            imm32         = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            dec.alu_src2  = 1'b1;
            dec.mem_write = 1'b1;
         end
         OP_IMM: begin
            imm32        = {{20{ins[31]}}, ins[31:20]};
            dec.alu_src2 = 1'b1;
            dec.alu_op   = 2'b11;
            wr           = 1'b1;
         end
         OP_REG: begin
            dec.alu_op = 2'b10;
            wr         = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
      dec.imm       = XLEN'($signed(imm32));
      // Writes to x0 are architecturally dead, so never request them.
      dec.reg_write = wr & (ins[11:7] != 5'd0);
   end

   pkt_t          mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          push;
   logic          pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign bus.in_ready  = (cnt < CW'(DEPTH));
   assign bus.out_valid = (cnt != '0);
   assign push          = bus.in_valid & bus.in_ready & ~bus.flush;
   assign pop           = bus.out_valid & bus.out_ready & ~bus.flush;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (bus.flush) begin
         cnt    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= nxt(wr_ptr);
         if (pop)  rd_ptr <= nxt(rd_ptr);
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: an empty buffer masks every entry to a zero bubble.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= dec;
   end

   assign head = bus.out_valid ? mem[rd_ptr] : '0;

   assign bus.out_pc     = head.pc;
   assign bus.opcode     = head.opcode;
   assign bus.rd         = head.rd;
   assign bus.funct3     = head.funct3;
   assign bus.rs1        = head.rs1;
   assign bus.rs2        = head.rs2;
   assign bus.funct7     = head.funct7;
   assign bus.imm        = head.imm;
   assign bus.alu_src1   = head.alu_src1;
   assign bus.alu_src2   = head.alu_src2;
   assign bus.alu_op     = head.alu_op;
   assign bus.mem_read   = head.mem_read;
   assign bus.mem_write  = head.mem_write;
   assign bus.mem_to_reg = head.mem_to_reg;
   assign bus.reg_write  = head.reg_write;
   assign bus.is_branch  = head.is_branch;
   assign bus.is_jump    = head.is_jump;
   assign bus.illegal    = head.illegal;
   assign bus.count      = cnt;
endmodule

// File: tb/tb_id_ex_buf.sv
// Scoreboard bench: a 32-bit/2-entry and a 64-bit/1-entry instance driven with directed vectors.
module tb_id_ex_buf;
   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   cyc  = 0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [63:0] pc;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [6:0]  f7;
      logic [63:0] imm;
      logic [10:0] ctl;
   } exp_t;

   exp_t q32[$];
   exp_t q64[$];

   id_ex_buf_if #(.XLEN(32), .DEPTH(2)) b32 ();
   id_ex_buf_if #(.XLEN(64), .DEPTH(1)) b64 ();

   id_ex_buf #(.XLEN(32), .DEPTH(2)) u32 (.clk_i(clk), .rstn_i(rstn), .bus(b32));
   id_ex_buf #(.XLEN(64), .DEPTH(1)) u64 (.clk_i(clk), .rstn_i(rstn), .bus(b64));

   // ctl packing: {src1, src2, alu_op[1:0], mem_read, mem_write, mem_to_reg, reg_write, branch, jump, illegal}
   function automatic logic [10:0] ctl(bit s1, bit s2, bit [1:0] op, bit mr, bit mw,
                                       bit m2r, bit rw, bit br, bit jp, bit il);
      return {s1, s2, op, mr, mw, m2r, rw, br, jp, il};
   endfunction

   function automatic exp_t mk(logic [63:0] pc, logic [31:0] ins, logic [4:0] rs1,
                               logic [63:0] imm, logic [10:0] c);
      exp_t e;
      e.pc = pc; e.opcode = ins[6:0]; e.rd = ins[11:7]; e.f3 = ins[14:12];
      e.rs1 = rs1; e.rs2 = ins[24:20]; e.f7 = ins[31:25]; e.imm = imm; e.ctl = c;
      return e;
   endfunction

   function automatic exp_t act32();
      exp_t a;
      a.pc = 64'(b32.out_pc); a.opcode = b32.opcode; a.rd = b32.rd; a.f3 = b32.funct3;
      a.rs1 = b32.rs1; a.rs2 = b32.rs2; a.f7 = b32.funct7; a.imm = 64'(b32.imm);
      a.ctl = {b32.alu_src1, b32.alu_src2, b32.alu_op, b32.mem_read, b32.mem_write,
               b32.mem_to_reg, b32.reg_write, b32.is_branch, b32.is_jump, b32.illegal};
      return a;
   endfunction

   function automatic exp_t act64();
      exp_t a;
      a.pc = b64.out_pc; a.opcode = b64.opcode; a.rd = b64.rd; a.f3 = b64.funct3;
      a.rs1 = b64.rs1; a.rs2 = b64.rs2; a.f7 = b64.funct7; a.imm = b64.imm;
      a.ctl = {b64.alu_src1, b64.alu_src2, b64.alu_op, b64.mem_read, b64.mem_write,
               b64.mem_to_reg, b64.reg_write, b64.is_branch, b64.is_jump, b64.illegal};
      return a;
   endfunction

   task automatic chk(input string nm, input logic [191:0] a, input logic [191:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   // Monitors: compare the head against the scoreboard whenever it is consumed.
   always @(negedge clk) begin
      if (rstn) begin
         if (b32.out_valid && b32.out_ready && !b32.flush) begin
            if (q32.size() == 0) chk("pop32_unexpected", 192'(act32()), 192'(0));
            else chk("pkt32", 192'(act32()), 192'(q32.pop_front()));
         end else if (!b32.out_valid) begin
            chk("bubble32", 192'(act32()), 192'(0));
         end
      end
   end

   always @(negedge clk) begin
      if (rstn) begin
         if (b64.out_valid && b64.out_ready && !b64.flush) begin
            if (q64.size() == 0) chk("pop64_unexpected", 192'(act64()), 192'(0));
            else chk("pkt64", 192'(act64()), 192'(q64.pop_front()));
         end else if (!b64.out_valid) begin
            chk("bubble64", 192'(act64()), 192'(0));
         end
      end
   end

   task automatic send32(input logic [63:0] pc, input logic [31:0] ins, input exp_t e, output int t);
      b32.in_valid = 1'b1; b32.in_pc = pc[31:0]; b32.in_instr = ins; t = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (b32.in_ready) begin
            q32.push_back(e); t = cyc;
            @(posedge clk); #1;
            break;
         end
      end
      if (t < 0) chk("send32_timeout", 192'(0), 192'(1));
   endtask

   task automatic send64(input logic [63:0] pc, input logic [31:0] ins, input exp_t e, output int t);
      b64.in_valid = 1'b1; b64.in_pc = pc; b64.in_instr = ins; t = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (b64.in_ready) begin
            q64.push_back(e); t = cyc;
            @(posedge clk); #1;
            break;
         end
      end
      if (t < 0) chk("send64_timeout", 192'(0), 192'(1));
   endtask

   task automatic drain32();
      int i = 0;
      while ((q32.size() != 0 || b32.count != 0) && i < 100) begin @(negedge clk); i++; end
      chk("drain32", 192'(q32.size() + int'(b32.count)), 192'(0));
      @(posedge clk); #1;
   endtask

   task automatic drain64();
      int i = 0;
      while ((q64.size() != 0 || b64.count != 0) && i < 100) begin @(negedge clk); i++; end
      chk("drain64", 192'(q64.size() + int'(b64.count)), 192'(0));
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   logic [31:0] bi [8];
   exp_t        be [8];

   initial begin
      int t0, t1, slow;

      bi[0] = 32'h002081B3; be[0] = mk(64'h300, bi[0], 5'd1,  64'h0,         ctl(0,0,2'b10,0,0,0,1,0,0,0));
      bi[1] = 32'h0020A423; be[1] = mk(64'h304, bi[1], 5'd1,  64'h8,         ctl(0,1,2'b00,0,1,0,0,0,0,0));
      bi[2] = 32'h010000EF; be[2] = mk(64'h308, bi[2], 5'd0,  64'h10,        ctl(1,0,2'b00,0,0,0,1,0,1,0));
      bi[3] = 32'h12345397; be[3] = mk(64'h30C, bi[3], 5'd8,  64'h12345000,  ctl(1,1,2'b00,0,0,0,1,0,0,0));
      bi[4] = 32'h00008067; be[4] = mk(64'h310, bi[4], 5'd1,  64'h0,         ctl(1,1,2'b00,0,0,0,0,0,1,0));
      bi[5] = 32'h0000007F; be[5] = mk(64'h314, bi[5], 5'd0,  64'h0,         ctl(0,0,2'b00,0,0,0,0,0,0,1));
      bi[6] = 32'hFFFFFFFF; be[6] = mk(64'h318, bi[6], 5'd31, 64'h0,         ctl(0,0,2'b00,0,0,0,0,0,0,1));
      bi[7] = 32'h00000013; be[7] = mk(64'h31C, bi[7], 5'd0,  64'h0,         ctl(0,1,2'b11,0,0,0,0,0,0,0));

      b32.in_valid = 0; b32.in_pc = '0; b32.in_instr = '0; b32.flush = 0; b32.out_ready = 0;
      b64.in_valid = 0; b64.in_pc = '0; b64.in_instr = '0; b64.flush = 0; b64.out_ready = 0;
      repeat (3) @(posedge clk); #1;
      chk("rst32_state", 192'({b32.out_valid, b32.in_ready, b32.count}), 192'(4'b0100));
      chk("rst64_state", 192'({b64.out_valid, b64.in_ready, b64.count}), 192'(3'b010));
      chk("rst32_outs", 192'(act32()), 192'(0));
      rstn = 1'b1;
      @(posedge clk); #1;

      // addi x1,x0,5
      send32(64'h100, 32'h00500093, mk(64'h100, 32'h00500093, 5'd0, 64'h5, ctl(0,1,2'b11,0,0,0,1,0,0,0)), t0);
      b32.in_valid = 0;
      chk("t1_count", 192'(b32.count), 192'(1));
      chk("t1_valid", 192'(b32.out_valid), 192'(1));
      b32.out_ready = 1;
      drain32();

      // lw x2,-4(x1) then beq x1,x2,-8, back to back
      send32(64'h104, 32'hFFC0A103, mk(64'h104, 32'hFFC0A103, 5'd1, 64'hFFFFFFFC, ctl(0,1,2'b00,1,0,1,1,0,0,0)), t0);
      send32(64'h108, 32'hFE208CE3, mk(64'h108, 32'hFE208CE3, 5'd1, 64'hFFFFFFF8, ctl(0,0,2'b01,0,0,0,0,1,0,0)), t1);
      b32.in_valid = 0;
      chk("t2_gap", 192'(t1 - t0), 192'(1));
      drain32();

      slow = 0;
      for (int i = 0; i < 8; i++) begin
         send32(64'h300 + 64'(4 * i), bi[i], be[i], t1);
         if (i > 0 && t1 - t0 != 1) slow++;
         t0 = t1;
      end
      b32.in_valid = 0;
      chk("batch_thru_stalls", 192'(slow), 192'(0));
      drain32();

      // Backpressure: third packet must wait upstream, head must not move.
      b32.out_ready = 0;
      send32(64'h200, bi[0], mk(64'h200, bi[0], 5'd1, 64'h0, ctl(0,0,2'b10,0,0,0,1,0,0,0)), t0);
      chk("bp_count1", 192'({b32.count, b32.in_ready}), 192'(3'b011));
      send32(64'h204, bi[1], mk(64'h204, bi[1], 5'd1, 64'h8, ctl(0,1,2'b00,0,1,0,0,0,0,0)), t0);
      chk("bp_count2", 192'({b32.count, b32.in_ready}), 192'(3'b100));
      fork
         send32(64'h208, bi[3], mk(64'h208, bi[3], 5'd8, 64'h12345000, ctl(1,1,2'b00,0,0,0,1,0,0,0)), t1);
         begin
            repeat (3) begin
               @(negedge clk);
               chk("bp_in_ready", 192'(b32.in_ready), 192'(0));
               chk("bp_head_pc", 192'(b32.out_pc), 192'(32'h200));
            end
            @(posedge clk); #1;
            b32.out_ready = 1;
         end
      join
      b32.in_valid = 0;
      drain32();

      // Flush while full with a pending upstream packet.
      b32.out_ready = 0;
      send32(64'h400, bi[0], mk(64'h400, bi[0], 5'd1, 64'h0, ctl(0,0,2'b10,0,0,0,1,0,0,0)), t0);
      send32(64'h404, bi[0], mk(64'h404, bi[0], 5'd1, 64'h0, ctl(0,0,2'b10,0,0,0,1,0,0,0)), t0);
      b32.in_pc = 32'h999; b32.in_instr = 32'h00500093; b32.in_valid = 1; b32.flush = 1;
      @(posedge clk); #1;
      b32.flush = 0; b32.in_valid = 0; q32.delete();
      chk("flush2_state", 192'({b32.out_valid, b32.in_ready, b32.count}), 192'(4'b0100));
      chk("flush2_outs", 192'(act32()), 192'(0));

      // Flush with room: the same-cycle push must still be dropped.
      send32(64'h500, bi[0], mk(64'h500, bi[0], 5'd1, 64'h0, ctl(0,0,2'b10,0,0,0,1,0,0,0)), t0);
      b32.in_pc = 32'h777; b32.in_instr = 32'h00500093; b32.in_valid = 1; b32.flush = 1;
      @(posedge clk); #1;
      b32.flush = 0; b32.in_valid = 0; q32.delete();
      chk("flush1_state", 192'({b32.out_valid, b32.in_ready, b32.count}), 192'(4'b0100));
      b32.out_ready = 1;
      repeat (5) @(posedge clk); #1;
      chk("flush_no_ghost", 192'(b32.out_valid), 192'(0));

      // Asynchronous reset in the middle of a stream.
      b32.out_ready = 0;
      send32(64'h600, bi[0], mk(64'h600, bi[0], 5'd1, 64'h0, ctl(0,0,2'b10,0,0,0,1,0,0,0)), t0);
      send32(64'h604, bi[1], mk(64'h604, bi[1], 5'd1, 64'h8, ctl(0,1,2'b00,0,1,0,0,0,0,0)), t0);
      b32.in_valid = 0;
      @(negedge clk); #2;
      rstn = 1'b0;
      #1;
      chk("arst_state", 192'({b32.out_valid, b32.in_ready, b32.count}), 192'(4'b0100));
      chk("arst_outs", 192'(act32()), 192'(0));
      q32.delete();
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;

      // 64-bit, single entry: lui x5,0x80000 fills it.
      b64.out_ready = 0;
      send64(64'h8000_0000_0000_1000, 32'h800002B7,
             mk(64'h8000_0000_0000_1000, 32'h800002B7, 5'd0, 64'hFFFFFFFF80000000, ctl(0,1,2'b00,0,0,0,1,0,0,0)), t0);
      b64.in_valid = 0;
      chk("d1_full", 192'({b64.count, b64.in_ready, b64.out_valid}), 192'(3'b101));
      b64.out_ready = 1;
      drain64();

      send64(64'h20, 32'h800FA2B7, mk(64'h20, 32'h800FA2B7, 5'd0, 64'hFFFFFFFF800FA000, ctl(0,1,2'b00,0,0,0,1,0,0,0)), t0);
      send64(64'h24, 32'hFFC0A103, mk(64'h24, 32'hFFC0A103, 5'd1, 64'hFFFFFFFFFFFFFFFC, ctl(0,1,2'b00,1,0,1,1,0,0,0)), t1);
      chk("d1_gap_a", 192'(t1 - t0), 192'(2));
      send64(64'h28, 32'hFE208CE3, mk(64'h28, 32'hFE208CE3, 5'd1, 64'hFFFFFFFFFFFFFFF8, ctl(0,0,2'b01,0,0,0,0,1,0,0)), t0);
      send64(64'h2C, 32'h12345397, mk(64'h2C, 32'h12345397, 5'd8, 64'h12345000, ctl(1,1,2'b00,0,0,0,1,0,0,0)), t1);
      chk("d1_gap_b", 192'(t1 - t0), 192'(2));
      b64.in_valid = 0;
      drain64();

      chk("queues_empty", 192'(q32.size() + q64.size()), 192'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/id_ex_buf.md
Name: id_ex_buf

Overview:
Parametrised successor to the ID/EX pipeline register. It decodes an RV32I/RV64I instruction word into immediate, operand-select and memory/writeback controls, then holds the decoded packets in a 1- or 2-entry elastic buffer. The buffer uses valid/ready handshakes on both sides and supports flush. It sits between the fetch/IF-ID stage and the execute stage. It replaces a fixed stall-zeroing register with backpressure-correct buffering.

Parameters:
XLEN, 32, datapath width of pc and imm; legal values are 32 and 64.
DEPTH, 2, number of buffer entries. DEPTH=1 gives at most one accept every other cycle under continuous drain. DEPTH=2 gives full throughput.

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
in_valid_i  in  1  upstream packet valid
in_ready_o  out  1  buffer can accept
pc_i  in  XLEN  instruction PC
instr_i  in  32  instruction word
flush_i  in  1  discard all held and incoming packets
out_valid_o  out  1  head packet valid
out_ready_i  in  1  execute consumes head
pc_o  out  XLEN  head PC
opcode_o  out  7  instr[6:0]
rd_o  out  5  instr[11:7]
funct3_o  out  3  instr[14:12]
rs1_o  out  5  instr[19:15]; forced 0 for LUI
rs2_o  out  5  instr[24:20]
funct7_o  out  7  instr[31:25]
imm_o  out  XLEN  sign-extended immediate
alu_src1_o  out  1  1 = PC operand
alu_src2_o  out  1  1 = imm operand
alu_op_o  out  2  00 add, 01 branch, 10 R-type, 11 OP-IMM
mem_read_o, mem_write_o, mem_to_reg_o, reg_write_o, is_branch_o, is_jump_o, illegal_o  out  1 each  control flags
count_o  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
Decode (combinational, on instr_i):
- Immediate by format: I (OP-IMM, LOAD, JALR), S, B, J, U (LUI, AUIPC); R-type gives 0. The sign bit is instr[31], extended to XLEN; U-type {instr[31:12],12'b0} is also sign-extended to XLEN.
- alu_src1=1 for JAL, JALR, AUIPC.
- alu_src2=1 for OP-IMM, LOAD, JALR, STORE, LUI, AUIPC.
- alu_op: R-type 10, OP-IMM 11, BRANCH 01, all others 00.
- Memory/writeback flags:
  - LOAD: mem_read=1, mem_to_reg=1.
  - STORE: mem_write=1.
  - is_branch=1 for opcode 1100011; is_jump=1 for JAL and JALR.
  - reg_write=1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, and only when rd≠0.
- Any other opcode sets illegal_o=1 with reg_write, mem_read and mem_write all 0; all other fields still pass through.

Buffer:
- Storage is a circular FIFO of DEPTH decoded packets.
- in_ready_o = (count < DEPTH). It is registered-state only, with no combinational path from out_ready_i.
- Push occurs on in_valid_i & in_ready_o & !flush_i. Pop occurs on out_valid_o & out_ready_i & !flush_i.
- out_valid_o = (count ≠ 0). All packet outputs come from the head entry.
- When count=0, every packet output reads 0 (bubble); this is mandatory, not don't-care.
- Simultaneous push and pop: count is unchanged and the pointers advance. With DEPTH=1, full, and a pop, there is no same-cycle refill.
- Full (count=DEPTH): in_ready_o=0, input is ignored, and no packet is lost.
- Head outputs hold stable while out_valid_o=1 & out_ready_i=0.
- Pointers wrap modulo DEPTH.

Flush:
- flush_i is synchronous and has highest priority.
- On the next edge, count=0 and pointers reset; a push or pop presented in the same cycle is discarded.
- in_ready_o=1 and out_valid_o=0 from the following cycle.

Reset:
- Asynchronous assert, synchronous deassert assumed at system level.
- All outputs are 0, count_o=0, in_ready_o=1. This includes reset mid-transfer.

Test Plan:
- Reset, then push 0x00500093 (addi x1,x0,5) at pc 0x100 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, alu_src2=1, alu_op=11, reg_write=1, illegal=0, count=1.
- Push 0xFFC0A103 (lw x2,-4(x1)) then 0xFE208CE3 (beq x1,x2,-8), out_ready=1, XLEN=32 -> first packet: imm=0xFFFFFFFC, mem_read=1, mem_to_reg=1. Second packet: imm=0xFFFFFFF8, is_branch=1, alu_op=01, reg_write=0.
- XLEN=64, push 0x800002B7 (lui x5,0x80000) -> imm=0xFFFFFFFF80000000, rs1_o=0, rd=5, alu_src2=1.
- DEPTH=2, out_ready=0, push 3 packets continuously -> count 1, then 2; in_ready drops after the 2nd push; the 3rd is held upstream; head is unchanged. Raise out_ready -> packets drain in order and the 3rd is accepted with no loss.
- Edge cases, one packet each:
  - Push opcode 0x7F -> illegal=1, reg_write=0, mem_write=0.
  - Push 0x00000013 (addi x0) -> reg_write=0.
- With count=2, assert flush_i together with in_valid=1 -> next cycle count=0, out_valid=0, all outputs 0, in_ready=1; the flushed-cycle packet never appears. Separately, assert rstn_i=0 mid-stream -> outputs go to 0 immediately, without waiting for a clock edge.
